fetch_stage: RTL and testbench

Instruction-fetch stage that directly feeds the IF/ID pipeline register and consumes the hazard unit's pc_ld, IF_ID_write and flush outputs.
- Owns the fetch PC and a req/ready instruction-memory handshake with variable latency.
- Holds a one-entry skid buffer so a fetch that completes during a stall is not lost.
- Discards in-flight fetches on redirect and drives the IF/ID register outputs, inserting bubbles where needed.

---
 rtl/fetch_stage.sv | 199 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the fetch PC and a req/ready instruction-memory handshake with variable
// latency. A one-entry skid buffer keeps a fetch that completes during a stall.
// In-flight fetches are discarded on redirect. Bubbles are inserted into IF/ID
// where no instruction is available.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_ld, IF_ID_write  hazard-unit controls; either low means stall
//   flush, redirect_pc  redirect fetch to redirect_pc (flush has priority)
//   imem_req/addr       fetch request and address
//   imem_ready/rdata    transfer completes on an edge with imem_req & imem_ready
//   IF_ID_inst/pc_plus4/valid  registered instruction to ID
//   stall_cycles, flush_count  performance counters
//
// Optional build macro: FETCH_PERF_EN. When defined, the counters are
// implemented (saturating). When undefined, both counter ports are tied to 0.

module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_ld,
  input  logic        IF_ID_write,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc_plus4,
  output logic        IF_ID_valid,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        stall;
  logic        xfer;
  logic [31:0] pc_plus4;

  assign stall    = ~(pc_ld & IF_ID_write);
  assign xfer     = imem_req & imem_ready;
  assign pc_plus4 = pc_q + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch, StWait: begin
        if (flush)      state_d = xfer ? StFetch : StDrop;
        else if (xfer)  state_d = stall ? StHold : StFetch;
        else            state_d = StWait;
      end
      StHold: begin
        if (flush || !stall) state_d = StFetch;
      end
      StDrop: begin
        // Wrong-path response returning ends the drop even if a new flush
        // arrives on the same edge; the new target is already in pc_q.
        if (xfer) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Memory-side outputs
  always_comb begin
    imem_req  = ~rst & (state_q != StHold);
    imem_addr = (state_q == StDrop) ? drop_addr_q : pc_q;
  end

  // Datapath next-state: PC, drop address, skid buffer and IF/ID register
  always_comb begin
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    buf_inst_d  = buf_inst_q;
    buf_pc4_d   = buf_pc4_q;
    buf_valid_d = buf_valid_q;
    // IF/ID default: hold on a plain stall, bubble otherwise (flush always bubbles)
    if (flush || !stall) begin
      inst_d  = NOP_INST;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else begin
      inst_d  = inst_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end

    unique case (state_q)
      StFetch, StWait: begin
        if (flush) begin
          if (!xfer) drop_addr_d = pc_q;
          pc_d = redirect_pc;
        end else if (xfer) begin
          pc_d = pc_plus4;
          if (!stall) begin
            inst_d  = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end else begin
            buf_inst_d  = imem_rdata;
            buf_pc4_d   = pc_plus4;
            buf_valid_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (flush) begin
          buf_valid_d = 1'b0;
          pc_d        = redirect_pc;
        end else if (!stall && buf_valid_q) begin
          inst_d      = buf_inst_q;
          pc4_d       = buf_pc4_q;
          valid_d     = 1'b1;
          buf_valid_d = 1'b0;
        end
      end
      StDrop: begin
        if (flush) pc_d = redirect_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= PC_RESET;
      drop_addr_q <= 32'd0;
      buf_inst_q  <= 32'd0;
      buf_pc4_q   <= 32'd0;
      buf_valid_q <= 1'b0;
      inst_q      <= NOP_INST;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc4_q   <= buf_pc4_d;
      buf_valid_q <= buf_valid_d;
      inst_q      <= inst_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  assign IF_ID_inst     = inst_q;
  assign IF_ID_pc_plus4 = pc4_q;
  assign IF_ID_valid    = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if ((state_q == StWait || state_q == StDrop) && stall_cycles_q != 32'hFFFF_FFFF) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush && flush_count_q != 32'hFFFF_FFFF) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, pc_ld, IF_ID_write, flush, imem_ready;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] IF_ID_inst, IF_ID_pc_plus4;
  logic        IF_ID_valid;
  logic [31:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_ld         (pc_ld),
    .IF_ID_write   (IF_ID_write),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .IF_ID_inst    (IF_ID_inst),
    .IF_ID_pc_plus4(IF_ID_pc_plus4),
    .IF_ID_valid   (IF_ID_valid),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  // Instruction memory contents: a fixed hash of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: next fetch address, optional outstanding wrong-path
  // request, skid queue (at most one entry), expected IF/ID contents.
  logic [31:0] m_pc, m_drop_addr;
  logic        m_drop, m_waiting;
  logic [63:0] skid[$];
  logic [31:0] e_inst, e_pc4;
  logic        e_valid;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic bubble();
    e_inst  = 32'h0;
    e_pc4   = 32'h0;
    e_valid = 1'b0;
  endtask

  task automatic model_step();
    logic c, st;
    st = !(pc_ld && IF_ID_write);
    if (rst) begin
      m_pc = 32'h0; m_drop_addr = 32'h0; m_drop = 1'b0; m_waiting = 1'b0;
      skid.delete();
      bubble();
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      c = (skid.size() == 0) && imem_ready;
      if ((m_drop || m_waiting) && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
      if (skid.size() != 0) begin
        if (flush) begin
          skid.delete();
          m_pc = redirect_pc;
          bubble();
        end else if (!st) begin
          {e_inst, e_pc4} = skid.pop_front();
          e_valid = 1'b1;
        end
        m_waiting = 1'b0;
      end else if (m_drop) begin
        if (flush) m_pc = redirect_pc;
        if (c) m_drop = 1'b0;
        if (flush || !st) bubble();
      end else if (flush) begin
        if (!c) begin
          m_drop      = 1'b1;
          m_drop_addr = m_pc;
        end
        m_pc = redirect_pc;
        m_waiting = 1'b0;
        bubble();
      end else if (c) begin
        if (!st) begin
          e_inst  = mem_word(m_pc);
          e_pc4   = m_pc + 32'd4;
          e_valid = 1'b1;
        end else begin
          skid.push_back({mem_word(m_pc), m_pc + 32'd4});
        end
        m_pc = m_pc + 32'd4;
        m_waiting = 1'b0;
      end else begin
        m_waiting = 1'b1;
        if (!st) bubble();
      end
    end
  endtask

  task automatic check_outputs();
    logic req_exp;
    req_exp = !rst && (skid.size() == 0);
    chk("imem_req", {31'b0, imem_req}, {31'b0, req_exp});
    if (req_exp) chk("imem_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
    chk("IF_ID_inst", IF_ID_inst, e_inst);
    chk("IF_ID_pc_plus4", IF_ID_pc_plus4, e_pc4);
    chk("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, e_valid});
`ifdef FETCH_PERF_EN
    chk("stall_cycles", stall_cycles, m_stall_cnt);
    chk("flush_count", flush_count, m_flush_cnt);
`else
    chk("stall_cycles", stall_cycles, 32'h0);
    chk("flush_count", flush_count, 32'h0);
`endif
  endtask

  task automatic cycle(input logic r, input logic pl, input logic iw, input logic fl,
                       input logic [31:0] rd, input logic rdy);
    rst = r; pc_ld = pl; IF_ID_write = iw; flush = fl; redirect_pc = rd; imem_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic r, pl, iw, fl, rdy;
    logic [31:0] rd;

    // Reset
    cycle(1, 1, 1, 0, 0, 1);
    cycle(1, 1, 1, 0, 0, 1);
    chk("reset_valid", {31'b0, IF_ID_valid}, 32'h0);

    // Zero-wait streaming: 0, 4, 8, C
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0, 1);
    chk("stream_pc4", IF_ID_pc_plus4, 32'h10);
    chk("addr_0x10", imem_addr, 32'h10);

    // Memory not ready for three cycles at 0x10
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0);
    chk("wait_addr", imem_addr, 32'h10);
    chk("wait_bubble", {31'b0, IF_ID_valid}, 32'h0);
    cycle(0, 1, 1, 0, 0, 1);
    chk("wait_done_pc4", IF_ID_pc_plus4, 32'h14);
`ifdef FETCH_PERF_EN
    chk("wait_stall_cycles", stall_cycles, 32'd3);
`endif

    // Stall on completion of 0x20 -> skid buffer
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("hold_req", {31'b0, imem_req}, 32'h0);
    chk("hold_ifid_pc4", IF_ID_pc_plus4, 32'h20);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 1);
    chk("skid_pc4", IF_ID_pc_plus4, 32'h24);
    chk("after_skid_addr", imem_addr, 32'h24);

    // Flush while waiting at 0x40
    for (int i = 0; i < 7; i++) cycle(0, 1, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 32'h100, 0);
    chk("drop_addr", imem_addr, 32'h40);
    cycle(0, 1, 1, 0, 0, 1);
    chk("drop_discard", {31'b0, IF_ID_valid}, 32'h0);
    chk("redirect_addr", imem_addr, 32'h100);

    // Flush and stall together in HOLD
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 32'h200, 1);
    chk("hold_flush_valid", {31'b0, IF_ID_valid}, 32'h0);
    chk("hold_flush_addr", imem_addr, 32'h200);

    // Reset while waiting
    cycle(0, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    cycle(0, 1, 1, 0, 0, 0);
    chk("rst_restart_addr", imem_addr, 32'h0);

    // Randomised traffic including redirects near the top of the address space
    for (int i = 0; i < 500; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      pl  = ($urandom_range(0, 99) >= 15);
      iw  = ($urandom_range(0, 99) >= 15);
      fl  = ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 3) == 0) rd = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
      else                           rd = $urandom() & 32'hFFFF_FFFC;
      cycle(r, pl, iw, fl, rd, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
